// File: rtl/lc3_seq_ctrl_if.sv
// rtl/lc3_seq_ctrl_if.sv - sequencer control/status bundle between datapath stages and the LC-3 sequencer
interface lc3_seq_ctrl_if;
    logic        run;
    logic [15:0] IR;
    logic [2:0]  psr;
    logic        mem_ready;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        enable_updatePC;
    logic [1:0]  W_Control;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ind_sel;
    logic        br_taken;
    logic        illegal_op;
    logic        mem_err;

    modport slave (
        input  run, IR, psr, mem_ready,
        output enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC,
        output W_Control, mem_req, mem_we, mem_ind_sel, br_taken, illegal_op, mem_err
    );

    modport master (
        output run, IR, psr, mem_ready,
        input  enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC,
        input  W_Control, mem_req, mem_we, mem_ind_sel, br_taken, illegal_op, mem_err
    );
endinterface

// File: rtl/lc3_seq_ctrl.sv
// rtl/lc3_seq_ctrl.sv - multi-cycle LC-3 sequencer with memory handshake, indirection and timeout
module lc3_seq_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TW          = 4
) (
    input  logic           clock,
    input  logic           reset,
    lc3_seq_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM_IND, S_MEM, S_WB, S_UPD
    } state_t;

    localparam logic [TW-1:0] TIMEOUT_CNT = TW'(MEM_TIMEOUT);

    state_t        state, state_nxt;
    logic [3:0]    op_q;
    logic [2:0]    nzp_q;
    logic          br_q;
    logic          err_q;
    logic [TW-1:0] wait_cnt;

    logic is_load, is_store, is_ind, writes, is_illegal;
    logic in_mem, timeout, br_nxt;

    // Opcode classes are derived from the latched opcode, so they stay stable EXEC..UPD.
    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_ind     = 1'b0;
        writes     = 1'b0;
        is_illegal = 1'b0;
        case (op_q)
            4'b0001, 4'b0101, 4'b1001, 4'b1110, 4'b0100: writes = 1'b1;
            4'b0010, 4'b0110: begin is_load = 1'b1; writes = 1'b1; end
            4'b1010: begin is_load = 1'b1; writes = 1'b1; is_ind = 1'b1; end
            4'b0011, 4'b0111: is_store = 1'b1;
            4'b1011: begin is_store = 1'b1; is_ind = 1'b1; end
            4'b1000, 4'b1101, 4'b1111: is_illegal = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        br_nxt = 1'b0;
        case (op_q)
            4'b0000:          br_nxt = |(nzp_q & bus.psr);
            4'b1100, 4'b0100: br_nxt = 1'b1;
            default:          br_nxt = 1'b0;
        endcase
    end

    assign in_mem  = (state == S_MEM_IND) || (state == S_MEM);
    assign timeout = in_mem && !bus.mem_ready && (wait_cnt == TIMEOUT_CNT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            op_q     <= 4'd0;
            nzp_q    <= 3'd0;
            br_q     <= 1'b0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) begin
                op_q  <= bus.IR[15:12];
                nzp_q <= bus.IR[11:9];
            end
            if (state == S_EXEC)
                br_q <= br_nxt;
            // Counter restarts on every entry into a memory state, including MEM_IND -> MEM.
            wait_cnt <= (in_mem && state_nxt == state) ? wait_cnt + TW'(1) : '0;
            err_q    <= timeout;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.run) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                if (is_ind)                   state_nxt = S_MEM_IND;
                else if (is_load || is_store) state_nxt = S_MEM;
                else if (writes)              state_nxt = S_WB;
                else                          state_nxt = S_UPD;
            end
            S_MEM_IND: begin
                if (bus.mem_ready)  state_nxt = S_MEM;
                else if (timeout)   state_nxt = S_UPD;
            end
            S_MEM: begin
                if (bus.mem_ready)  state_nxt = is_load ? S_WB : S_UPD;
                else if (timeout)   state_nxt = S_UPD;
            end
            S_WB:     state_nxt = S_UPD;
            S_UPD:    state_nxt = bus.run ? S_FETCH : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.enable_fetch     = (state == S_FETCH);
        bus.enable_decode    = (state == S_DECODE);
        bus.enable_execute   = (state == S_EXEC);
        bus.enable_writeback = (state == S_WB);
        bus.enable_updatePC  = (state == S_UPD);
        bus.mem_req          = in_mem;
        bus.mem_we           = (state == S_MEM) && is_store;
        bus.mem_ind_sel      = (state == S_MEM) && is_ind;
        bus.br_taken         = (state == S_UPD) && br_q;
        bus.illegal_op       = (state == S_EXEC) && is_illegal;
        bus.mem_err          = err_q;
        bus.W_Control        = 2'd0;
        if (state == S_EXEC || state == S_MEM_IND || state == S_MEM ||
            state == S_WB || state == S_UPD) begin
            if (is_load)               bus.W_Control = 2'd1;
            else if (op_q == 4'b1110)  bus.W_Control = 2'd2;
            else if (op_q == 4'b0100)  bus.W_Control = 2'd3;
            else                       bus.W_Control = 2'd0;
        end
    end
endmodule

// File: tb/tb_lc3_seq_ctrl.sv
// tb/tb_lc3_seq_ctrl.sv - scoreboard bench for lc3_seq_ctrl with randomized instruction stream
module tb_lc3_seq_ctrl;
    localparam int MEM_TIMEOUT = 15;

    logic clock = 1'b0;
    logic reset = 1'b1;

    lc3_seq_ctrl_if bus ();

    lc3_seq_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .TW(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int len; int wb; int wctl_exec; int wctl_upd; int memreq;
        int we; int ind; int ill; int err; int br;
    } rec_t;

    typedef struct {
        logic [15:0] ir; logic [2:0] psr; int l0; int l1;
    } stim_t;

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   lat[2];
    int   phase = 0;
    int   cnt   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [12:0] outs();
        return {bus.enable_fetch, bus.enable_decode, bus.enable_execute, bus.enable_writeback,
                bus.enable_updatePC, bus.W_Control, bus.mem_req, bus.mem_we, bus.mem_ind_sel,
                bus.br_taken, bus.illegal_op, bus.mem_err};
    endfunction

    // Reference: per-instruction totals derived from opcode class and memory latencies.
    function automatic rec_t model(input logic [15:0] ir, input logic [2:0] psr, input int l0, input int l1);
        rec_t r;
        int op, nph, mc, l, lats[2];
        bit writes, mem, ind, store, load, stuck, last;
        r = '{default: 0};
        op = int'(ir[15:12]);
        lats[0] = l0; lats[1] = l1;
        writes = op inside {1, 5, 9, 14, 4, 2, 6, 10};
        mem    = op inside {2, 3, 6, 7, 10, 11};
        ind    = op inside {10, 11};
        store  = op inside {3, 7, 11};
        load   = op inside {2, 6, 10};
        stuck  = 0;
        mc     = 0;
        nph    = ind ? 2 : (mem ? 1 : 0);
        for (int p = 0; p < nph; p++) begin
            last = (p == nph - 1);
            l = lats[p];
            if (l == 0 || l > MEM_TIMEOUT + 1) begin
                l = MEM_TIMEOUT + 1;
                stuck = 1;
            end
            mc += l;
            if (last) begin
                r.we  = store ? l : 0;
                r.ind = ind ? l : 0;
            end
            if (stuck) break;
        end
        r.memreq    = mc;
        r.err       = stuck ? 1 : 0;
        r.wb        = (writes && !stuck) ? 1 : 0;
        r.ill       = (op inside {8, 13, 15}) ? 1 : 0;
        r.wctl_exec = load ? 1 : (op == 14 ? 2 : (op == 4 ? 3 : 0));
        r.wctl_upd  = r.wctl_exec;
        r.br        = (op == 0) ? int'(|(ir[11:9] & psr)) : ((op == 12 || op == 4) ? 1 : 0);
        r.len       = 3 + mc + r.wb + 1;
        return r;
    endfunction

    // Memory responder: raises mem_ready on the programmed cycle of each request phase,
    // and toggles it randomly while nothing is requested.
    always @(negedge clock) begin
        if (bus.mem_req) begin
            bus.mem_ready = 1'b0;
            cnt++;
            if (phase < 2 && lat[phase] != 0 && cnt == lat[phase]) begin
                bus.mem_ready = 1'b1;
                phase++;
                cnt = 0;
            end
        end else begin
            bus.mem_ready = 1'($urandom_range(0, 1));
        end
    end

    rec_t act;
    bit   active = 0;

    always @(negedge clock) begin
        if (reset) begin
            active = 0;
        end else begin
            if (bus.enable_fetch) begin
                active = 1;
                act = '{default: 0};
            end
            if (active) begin
                act.len++;
                act.wb     += int'(bus.enable_writeback);
                act.memreq += int'(bus.mem_req);
                act.we     += int'(bus.mem_we);
                act.ind    += int'(bus.mem_ind_sel);
                act.ill    += int'(bus.illegal_op);
                act.err    += int'(bus.mem_err);
                if (bus.enable_execute) act.wctl_exec = int'(bus.W_Control);
                if (bus.enable_updatePC) begin
                    rec_t e;
                    act.br       = int'(bus.br_taken);
                    act.wctl_upd = int'(bus.W_Control);
                    active = 0;
                    check("queue_depth_at_upd", exp_q.size(), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("cycles",      act.len,       e.len);
                        check("wb_pulses",   act.wb,        e.wb);
                        check("wctl_exec",   act.wctl_exec, e.wctl_exec);
                        check("wctl_upd",    act.wctl_upd,  e.wctl_upd);
                        check("mem_req_cyc", act.memreq,    e.memreq);
                        check("mem_we_cyc",  act.we,        e.we);
                        check("ind_sel_cyc", act.ind,       e.ind);
                        check("illegal_op",  act.ill,       e.ill);
                        check("mem_err",     act.err,       e.err);
                        check("br_taken",    act.br,        e.br);
                    end
                end
            end
        end
    end

    task automatic wait_sig(input int sel, output bit ok);
        ok = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if ((sel == 0 && bus.enable_fetch) || (sel == 1 && bus.enable_execute) ||
                (sel == 2 && bus.enable_updatePC) || (sel == 3 && bus.mem_req)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("wait_timeout", sel, -1);
    endtask

    stim_t stims[$];

    initial begin
        bit    ok;
        stim_t s;
        rec_t  e;
        bus.run = 1'b0; bus.IR = 16'h0; bus.psr = 3'b0; bus.mem_ready = 1'b0;
        lat[0] = 1; lat[1] = 1;

        stims.push_back('{16'h1042, 3'b010, 0, 0});
        stims.push_back('{16'h2005, 3'b010, 3, 0});
        stims.push_back('{16'hA003, 3'b010, 1, 1});
        stims.push_back('{16'h0402, 3'b010, 0, 0});
        stims.push_back('{16'h0402, 3'b001, 0, 0});
        stims.push_back('{16'h3001, 3'b100, 0, 0});
        stims.push_back('{16'hB1C0, 3'b100, 2, 4});
        stims.push_back('{16'h4800, 3'b001, 0, 0});
        stims.push_back('{16'hC1C0, 3'b001, 0, 0});
        stims.push_back('{16'hE000, 3'b001, 0, 0});
        stims.push_back('{16'h6000, 3'b001, 16, 0});
        stims.push_back('{16'h7000, 3'b001, 17, 0});
        stims.push_back('{16'hA000, 3'b001, 0, 1});
        stims.push_back('{16'h5000, 3'b001, 0, 0});
        stims.push_back('{16'h9000, 3'b001, 0, 0});
        stims.push_back('{16'h8000, 3'b001, 0, 0});
        stims.push_back('{16'hF000, 3'b001, 0, 0});
        for (int i = 0; i < 50; i++) begin
            s.ir  = 16'($urandom);
            s.psr = 3'($urandom_range(0, 7));
            s.l0  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
            s.l1  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
            stims.push_back(s);
        end
        stims.push_back('{16'hD000, 3'b001, 0, 0});

        repeat (3) @(negedge clock);
        check("reset_outputs", int'(outs()), 0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_outputs", int'(outs()), 0);
        bus.run = 1'b1;

        foreach (stims[i]) begin
            wait_sig(0, ok);
            if (!ok) break;
            s = stims[i];
            bus.IR  = s.ir;
            bus.psr = s.psr;
            lat[0] = s.l0; lat[1] = s.l1;
            phase = 0; cnt = 0;
            e = model(s.ir, s.psr, s.l0, s.l1);
            exp_q.push_back(e);
            if (i == stims.size() - 1) begin
                wait_sig(1, ok);
                bus.run = 1'b0;
            end
        end

        wait_sig(2, ok);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check("parked_idle", int'(outs()), 0);
        end
        check("queue_drained", exp_q.size(), 0);

        bus.run = 1'b1;
        wait_sig(0, ok);
        bus.IR = 16'h2000; bus.psr = 3'b010;
        lat[0] = 0; lat[1] = 0; phase = 0; cnt = 0;
        wait_sig(3, ok);
        repeat (3) @(negedge clock);
        check("mid_mem_req", int'(bus.mem_req), 1);
        reset = 1'b1;
        bus.run = 1'b0;
        @(negedge clock);
        check("abort_reset_outputs", int'(outs()), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("abort_idle_outputs", int'(outs()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
